reg_swap_engine: RTL
====================

REG_SWAP_ENGINE -- requirements
Module: reg_swap_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of each register entry.
REQ-002 SHALL have parameter DEPTH, default 4: number of register entries; must be a power of two, at least 2.
REQ-003 SHALL have parameter IW, default $clog2(DEPTH): index width.
REQ-004 SHALL have port clk  input  1: single clock, all state updates on posedge.
REQ-005 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-006 SHALL have port wr_en  input  1: write strobe.
REQ-007 SHALL have port wr_idx  input  IW: write index.
REQ-008 SHALL have port wr_data  input  WIDTH: write data.
REQ-009 SHALL have port rd_idx  input  IW: read index.
REQ-010 SHALL have port rd_data  output  WIDTH: combinational read of entry[rd_idx].
REQ-011 SHALL have port swap_req  input  1: request to exchange two entries.
REQ-012 SHALL have port swap_a  input  IW: first swap index.
REQ-013 SHALL have port swap_b  input  IW: second swap index.
REQ-014 SHALL have port swap_busy  output  1: high while a swap is in progress.
REQ-015 SHALL have port swap_done  output  1: one-cycle completion pulse.
REQ-016 SHALL have port temp_out  output  WIDTH: current value of the internal temp register, for debug.

Function
REQ-017 SHALL implement an FSM with states IDLE, SAVE, MOVE, RESTORE, DONE.
REQ-018 IDLE with swap_req=1 at posedge SHALL latch swap_a/swap_b into internal ia/ib and go to SAVE; swap_req in any other state SHALL be ignored (not queued).
REQ-019 SAVE SHALL do temp <= entry[ia], then go to MOVE.
REQ-020 MOVE SHALL do entry[ia] <= entry[ib], then go to RESTORE.
REQ-021 RESTORE SHALL do entry[ib] <= temp, then go to DONE.
REQ-022 DONE SHALL assert swap_done for exactly one cycle, then go to IDLE; the next swap_req can be accepted on the posedge that leaves DONE→IDLE +1, i.e. in IDLE only.
REQ-023 Latency: swap_done SHALL be high in the 4th cycle after the accepting edge; a full swap SHALL take 5 cycles, IDLE to IDLE.
REQ-024 swap_busy SHALL be high in SAVE, MOVE and RESTORE, and low in IDLE and DONE.
REQ-025 wr_en SHALL write entry[wr_idx] <= wr_data only when the FSM is in IDLE or DONE; wr_en SHALL be ignored while swap_busy=1.
REQ-026 When wr_en and swap_req occur on the same IDLE edge, the write SHALL commit on that edge, the swap SHALL be accepted, and SAVE SHALL observe the written value.
REQ-027 When ia==ib, the swap SHALL run the full sequence, leave entry contents unchanged, and still pulse swap_done.
REQ-028 temp SHALL hold its value outside SAVE; entries not indexed by ia/ib SHALL never change during a swap.
REQ-029 rd_data SHALL reflect entry state combinationally, including intermediate values during MOVE and RESTORE.

Reset
REQ-030 With rst=1 at posedge, all entries, temp, ia and ib SHALL become 0; the FSM SHALL go to IDLE; swap_busy and swap_done SHALL be 0.
REQ-031 rst SHALL take priority over wr_en and swap_req; reset mid-swap SHALL abort the swap with no further entry updates.

Verification
REQ-032 Write entry0=10 and entry1=20, then swap_req with a=0, b=1 → busy for 3 cycles, done pulse at cycle 4, then rd entry0=20, entry1=10, temp_out=10.
REQ-033 Swap with a=b=2, entry2=7 → entry2 stays 7, done pulses once, and the other entries are unchanged.
REQ-034 wr_en entry3=55 while busy → entry3 is unchanged after the swap; the same write issued in DONE → entry3=55.
REQ-035 swap_req held high continuously → swaps are accepted only from IDLE, one per 5 cycles, with a=0, b=1 toggling values 10↔20 each completion.
REQ-036 rst asserted in MOVE → next cycle all entries are 0, busy=0, done=0, and no done pulse follows.
REQ-037 Same-edge write entry0=33 plus swap a=0, b=1 (entry1=20) → final entry0=20, entry1=33.

Source files
------------

// File: rtl/reg_swap_engine.sv
// Small register file with a built-in swap engine. A swap exchanges two
// entries through a temp register over a fixed five-cycle sequence
// (IDLE -> SAVE -> MOVE -> RESTORE -> DONE -> IDLE). Host writes are only
// honoured while the engine is not moving data (IDLE and DONE).
module reg_swap_engine #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_data,
    input  logic             swap_req,
    input  logic [IW-1:0]    swap_a,
    input  logic [IW-1:0]    swap_b,
    output logic             swap_busy,
    output logic             swap_done,
    output logic [WIDTH-1:0] temp_out
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAVE    = 3'd1,
        MOVE    = 3'd2,
        RESTORE = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] entry_r [DEPTH];
    logic [WIDTH-1:0] temp_r;
    logic [IW-1:0]    ia_r;
    logic [IW-1:0]    ib_r;
    logic             busy_r;
    logic             done_r;

    // Swap sequencer, register file updates and registered status flags.
    // busy/done are set on the edge that enters the corresponding state so
    // they line up exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= {WIDTH{1'b0}};
            end
            temp_r  <= {WIDTH{1'b0}};
            ia_r    <= {IW{1'b0}};
            ib_r    <= {IW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    // A same-edge write lands before SAVE samples the entry.
                    if (wr_en) begin
                        entry_r[wr_idx] <= wr_data;
                    end
                    if (swap_req) begin
                        ia_r    <= swap_a;
                        ib_r    <= swap_b;
                        busy_r  <= 1'b1;
                        state_r <= SAVE;
                    end else begin
                        state_r <= IDLE;
                    end
                    done_r <= 1'b0;
                end
                SAVE: begin
                    temp_r  <= entry_r[ia_r];
                    state_r <= MOVE;
                end
                MOVE: begin
                    entry_r[ia_r] <= entry_r[ib_r];
                    state_r       <= RESTORE;
                end
                RESTORE: begin
                    // With ia == ib this rewrites the original value.
                    entry_r[ib_r] <= temp_r;
                    busy_r        <= 1'b0;
                    done_r        <= 1'b1;
                    state_r       <= DONE;
                end
                DONE: begin
                    // swap_req is deliberately not sampled here.
                    if (wr_en) begin
                        entry_r[wr_idx] <= wr_data;
                    end
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign rd_data   = entry_r[rd_idx];
    assign swap_busy = busy_r;
    assign swap_done = done_r;
    assign temp_out  = temp_r;

endmodule
